// File: rtl/mips_pkg.sv
// Shared MIPS datapath helpers: select-width function and elaboration limits
// for the retimed multiplexers.
package mips_pkg;

  localparam int MUX_MAX_INPUTS = 16;
  localparam int MUX_MAX_STAGES = 4;

  // A 1- or 2-input mux still needs a 1-bit select port.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One retiming stage: data plus valid/err qualifiers, with stall hold and
// flush-to-bubble.
module pipe_stage_reg
  import mips_pkg::*;
#(
  parameter int bits_num = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [bits_num-1:0] nxt_data,
  input  logic                nxt_valid,
  input  logic                nxt_err,
  output logic [bits_num-1:0] data,
  output logic                valid,
  output logic                err
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else if (!stall) begin
      data  <= nxt_data;
      valid <= nxt_valid;
      err   <= nxt_err;
    end
  end

endmodule

// File: rtl/pipe_mux.sv
// N:1 datapath multiplexer followed by a stall/flush-aware register chain,
// used for forwarding, writeback and PC source selection.
module pipe_mux
  import mips_pkg::*;
#(
  parameter int bits_num   = 32,
  parameter int inputs_num = 4,
  parameter int sel_bits   = clog2_safe(inputs_num),
  parameter int stages     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [inputs_num*bits_num-1:0] in_bus,
  input  logic [sel_bits-1:0]            sel,
  input  logic                           in_valid,
  input  logic                           stall,
  input  logic                           flush,
  output logic [bits_num-1:0]            out,
  output logic                           out_valid,
  output logic                           sel_err
);

  if (inputs_num < 2 || inputs_num > MUX_MAX_INPUTS) begin : g_bad_inputs
    $fatal(1, "pipe_mux: inputs_num must be 2..16");
  end
  if (stages < 1 || stages > MUX_MAX_STAGES) begin : g_bad_stages
    $fatal(1, "pipe_mux: stages must be 1..4");
  end
  if (bits_num < 1) begin : g_bad_width
    $fatal(1, "pipe_mux: bits_num must be at least 1");
  end
  if (sel_bits != clog2_safe(inputs_num)) begin : g_bad_sel
    $fatal(1, "pipe_mux: sel_bits is derived and must not be overridden");
  end

  logic [bits_num-1:0] mux_d;
  logic                err_d;
  logic [31:0]         sel_ext;

  assign sel_ext = 32'(sel);

  // Non-power-of-2 input counts leave select codes with no input behind them.
  always_comb begin
    mux_d = '0;
    err_d = 1'b1;
    for (int unsigned k = 0; k < inputs_num; k++) begin
      if (sel_ext == k) begin
        mux_d = in_bus[k*bits_num +: bits_num];
        err_d = 1'b0;
      end
    end
  end

  logic [bits_num-1:0] st_data  [0:stages];
  logic                st_valid [0:stages];
  logic                st_err   [0:stages];

  assign st_data[0]  = mux_d;
  assign st_valid[0] = in_valid;
  assign st_err[0]   = err_d & in_valid;

  for (genvar i = 0; i < stages; i++) begin : g_stage
    pipe_stage_reg #(
      .bits_num(bits_num)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .flush    (flush),
      .nxt_data (st_data[i]),
      .nxt_valid(st_valid[i]),
      .nxt_err  (st_err[i]),
      .data     (st_data[i+1]),
      .valid    (st_valid[i+1]),
      .err      (st_err[i+1])
    );
  end

  assign out       = st_data[stages];
  assign out_valid = st_valid[stages];
  assign sel_err   = st_err[stages];

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: several parameterisations share one stimulus stream and
// are checked each cycle against a per-configuration queue model.
module tb_pipe_mux;
  import mips_pkg::*;

  localparam int NCFG = 8;
  localparam int CFG_NI [NCFG] = '{4, 3, 4, 4, 2, 5, 16, 16};
  localparam int CFG_ST [NCFG] = '{2, 1, 3, 4, 1, 4, 1, 4};

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           stall = 1'b0;
  logic           flush = 1'b0;
  logic [3:0]     sel_all = '0;
  logic [16*32-1:0] bus_all = '0;

  logic [31:0] dout [NCFG];
  logic        dval [NCFG];
  logic        derr [NCFG];

  always #5 clk = ~clk;

  for (genvar c = 0; c < NCFG; c++) begin : g_dut
    localparam int NI = CFG_NI[c];
    localparam int SB = clog2_safe(NI);
    pipe_mux #(
      .bits_num  (32),
      .inputs_num(NI),
      .stages    (CFG_ST[c])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_bus   (bus_all[NI*32-1:0]),
      .sel      (sel_all[SB-1:0]),
      .in_valid (in_valid),
      .stall    (stall),
      .flush    (flush),
      .out      (dout[c]),
      .out_valid(dval[c]),
      .sel_err  (derr[c])
    );
  end

  typedef struct {
    logic [31:0] d;
    bit          v;
    bit          e;
    bit          z;  // bubble created by reset/flush: data must read 0
  } ent_t;

  ent_t hist [NCFG][$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d t=%0t: got %h want %h", name, c, $time, act, exp);
    end
  endtask

  // Model of the upcoming clock edge: each config is a FIFO holding exactly
  // "stages" entries; its head is what the output registers show.
  task automatic model_edge();
    for (int c = 0; c < NCFG; c++) begin
      if (rst || flush) begin
        hist[c].delete();
        for (int i = 0; i < CFG_ST[c]; i++) hist[c].push_back('{d: 32'h0, v: 1'b0, e: 1'b0, z: 1'b1});
      end else if (!stall) begin
        int   s;
        ent_t n;
        s = int'(sel_all) & ((1 << clog2_safe(CFG_NI[c])) - 1);
        n.d = (s < CFG_NI[c]) ? bus_all[s*32 +: 32] : 32'h0;
        n.v = in_valid;
        n.e = in_valid && (s >= CFG_NI[c]);
        n.z = 1'b0;
        hist[c].push_back(n);
        if (hist[c].size() > CFG_ST[c]) void'(hist[c].pop_front());
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCFG; c++) begin
      ent_t e;
      e = hist[c][0];
      chk("out_valid", c, 32'(dval[c]), 32'(e.v));
      chk("sel_err", c, 32'(derr[c]), 32'(e.e));
      if (e.v || e.z) chk("out", c, dout[c], e.d);
    end
  endtask

  task automatic tick(input bit r, input bit f, input bit s, input bit v, input logic [3:0] sl);
    rst = r; flush = f; stall = s; in_valid = v; sel_all = sl;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) bus_all[k*32 +: 32] = 32'(32'h11111111 * (k + 1));

    tick(1, 0, 0, 0, 4'd0);
    tick(1, 0, 0, 0, 4'd0);
    chk("rst_out", 0, dout[0], 32'h0);
    chk("rst_valid", 3, 32'(dval[3]), 32'h0);
    chk("rst_err", 3, 32'(derr[3]), 32'h0);

    // latency: stages=2 shows the captured word two edges later
    tick(0, 0, 0, 1, 4'd2);
    chk("lat1_out", 1, dout[1], 32'h33333333);
    chk("lat_early_valid", 0, 32'(dval[0]), 32'h0);
    idle(1);
    chk("lat_out", 0, dout[0], 32'h33333333);
    chk("lat_valid", 0, 32'(dval[0]), 32'h1);
    chk("lat_err", 0, 32'(derr[0]), 32'h0);

    // out-of-range select on the 3-input mux
    tick(0, 0, 0, 1, 4'd3);
    chk("oor_out", 1, dout[1], 32'h0);
    chk("oor_valid", 1, 32'(dval[1]), 32'h1);
    chk("oor_err", 1, 32'(derr[1]), 32'h1);
    tick(0, 0, 0, 0, 4'd3);
    chk("oor_inv_err", 1, 32'(derr[1]), 32'h0);
    chk("oor_inv_valid", 1, 32'(dval[1]), 32'h0);
    idle(4);

    // stall hold on the 3-stage config
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 4'(i));
    chk("pre_stall_out", 2, dout[2], 32'h22222222);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 1, 4'd0);
    chk("stall_out", 2, dout[2], 32'h22222222);
    chk("stall_valid", 2, 32'(dval[2]), 32'h1);
    idle(1);
    chk("resume1", 2, dout[2], 32'h33333333);
    idle(1);
    chk("resume2", 2, dout[2], 32'h44444444);
    idle(1);
    chk("resume_end", 2, 32'(dval[2]), 32'h0);
    idle(2);

    // flush beats stall
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 4'(i + 1));
    tick(0, 1, 1, 1, 4'd1);
    chk("flush_out", 3, dout[3], 32'h0);
    chk("flush_valid", 3, 32'(dval[3]), 32'h0);
    chk("flush_err", 7, 32'(derr[7]), 32'h0);
    tick(0, 0, 0, 1, 4'd1);
    idle(2);
    chk("post_flush_early", 3, 32'(dval[3]), 32'h0);
    idle(1);
    chk("post_flush_out", 3, dout[3], 32'h22222222);
    chk("post_flush_valid", 3, 32'(dval[3]), 32'h1);

    // reset mid-stream on the 4-stage config
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 4'(i + 4));
    tick(1, 0, 0, 1, 4'd2);
    chk("mid_rst_out", 3, dout[3], 32'h0);
    chk("mid_rst_valid", 3, 32'(dval[3]), 32'h0);
    chk("mid_rst_err", 5, 32'(derr[5]), 32'h0);
    idle(5);

    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 16; k++) bus_all[k*32 +: 32] = $urandom;
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 7,
           4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_mux.md
Name: pipe_mux

Overview:
- Parametrised N:1 datapath multiplexer with a configurable-depth pipeline register chain on its output.
- Carries valid qualification, stall hold and flush-to-bubble per stage.
- Intended for MIPS datapath points where a wide select must be retimed: ALU operand forwarding, writeback source select, and PC source select.
- Replaces ad-hoc cascades of 2:1 muxes plus separate stage registers.

Parameters:
- bits_num, 32, data width of each input and the output.
- inputs_num, 4, number of selectable inputs; legal range 2..16, need not be a power of 2.
- sel_bits, $clog2(inputs_num), width of the select; derived, never overridden.
- stages, 1, pipeline depth after the mux; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bus  input  inputs_num*bits_num  packed inputs; input k occupies bits [k*bits_num +: bits_num].
- sel  input  sel_bits  binary index of the selected input.
- in_valid  input  1  the current sel and in_bus are meaningful.
- stall  input  1  hold every stage; no data advances.
- flush  input  1  kill all in-flight entries.
- out  output  bits_num  data from the last stage.
- out_valid  output  1  out holds a live entry.
- sel_err  output  1  the entry in the last stage was captured with sel >= inputs_num.

Behaviour:
- Reset:
  - Synchronous, active-high, one clock.
  - While rst=1 at a clk edge, every stage data register is loaded with 0 and every valid/err bit with 0.
  - Hence out=0, out_valid=0, sel_err=0 from the edge after rst is sampled high.
- Reset mid-operation discards all entries, with no partial drain.
- Combinational select: mux_d = input[sel] when sel < inputs_num; otherwise mux_d = 0 and err_d = 1.
- Stage 0 capture, each clk edge with rst=0, flush=0, stall=0:
  - data0 <= mux_d.
  - valid0 <= in_valid.
  - err0 <= err_d & in_valid.
- Stage i>0 capture under the same condition: data_i, valid_i and err_i are loaded from stage i-1.
- Latency: an input presented at edge n appears on out after edge n+stages-1, i.e. "stages" clock edges after capture. There is no combinational path from in_bus to out.
- Stall=1, flush=0: all stage registers hold their values, and inputs presented that cycle are dropped. The upstream producer must hold its inputs.
- Flush=1: valid and err bits in every stage are cleared to 0, and data registers are cleared to 0.
  - Flush overrides stall.
  - Flush overrides in_valid in the same cycle, so the entry presented that cycle is also killed.
- Priority: rst > flush > stall > normal advance.
- Invalid entries still shift through the pipeline carrying data; out is only meaningful when out_valid=1. The verification engineer must not check out when out_valid=0, except after reset or flush, where out must equal 0.
- Outputs are driven directly from last-stage registers.
- Out-of-range sel is not an error when in_valid=0; no err bit is set.
- Width rules:
  - No arithmetic.
  - sel is compared zero-extended against inputs_num.
  - Illegal parameter values must stop elaboration.

Decomposition:
- Shared package mips_pkg holds:
  - the function clog2_safe, which returns 1 for inputs 1 and 2;
  - constants MUX_MAX_INPUTS=16 and MUX_MAX_STAGES=4, used for elaboration checks.
- One sub-module, pipe_stage_reg, implements a single stage:
  - contents: bits_num data + valid + err;
  - inputs: clk, rst, stall, flush.
- pipe_mux instantiates pipe_stage_reg "stages" times in a generate loop.
- The select logic stays in pipe_mux as a loop over inputs_num.

Test Plan:
- Basic latency: bits_num=32, inputs_num=4, stages=2. Inputs = 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid=1 at edge 5 -> out=0x33333333 with out_valid=1 after edge 6; sel_err=0.
- Non-power-of-2 range: inputs_num=3, sel=3, in_valid=1 -> after the latency, out=0, out_valid=1, sel_err=1. With sel=3 and in_valid=0 -> sel_err=0.
- Stall hold: stages=3, a stream of sel=0,1,2,3 on consecutive cycles, then stall=1 for 4 cycles -> out and out_valid are frozen. The sequence resumes in order with no loss or duplication of entries already captured.
- Flush beats stall: pipeline full with valid entries; assert stall=1 and flush=1 together for one cycle -> next cycle out_valid=0, out=0, sel_err=0 in all stages. The first post-flush capture appears after "stages" edges.
- Reset mid-stream: stages=4 full of valid data; rst=1 for one edge -> out=0, out_valid=0, sel_err=0 after that edge, and no stale entry ever emerges afterwards.
- Parameter sweep: inputs_num in {2,5,16} and stages in {1,4}. A random sel/in_valid/stall/flush stream is scoreboarded against a reference queue model with 0 mismatches over 10k cycles.
